// File: rtl/status_input_ctrl.sv
// Input side of the status display: synchronises and debounces the ON/OFF buttons and the
// open sensor, then runs the OFF/ON/OPEN/ERR status FSM that drives the one-hot result flags.
module status_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int ERR_HOLD_CYCLES = 100_000_000,
   parameter int CNT_W           = 27
) (
   input  logic clk_50MHz,
   input  logic reset_button,
   input  logic btn_on_raw,
   input  logic btn_off_raw,
   input  logic sw_open_raw,
   output logic result_on,
   output logic result_off,
   output logic result_err,
   output logic result_open
);

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(ERR_HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_OFF,
      ST_ON,
      ST_OPEN,
      ST_ERR
   } state_t;

   // Bit 0 = ON button, bit 1 = OFF button, bit 2 = open sensor.
   logic [2:0]       raw_in;
   logic [2:0]       sync_1;
   logic [2:0]       sync_2;
   logic [2:0]       deb;
   logic [1:0]       deb_prev;
   logic [CNT_W-1:0] deb_cnt [3];

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] next_hold_cnt;

   logic             press_on;
   logic             press_off;
   logic             both_held;
   logic             open_level;

   assign raw_in = {sw_open_raw, btn_off_raw, btn_on_raw};

   // A new level is accepted only after the synchronised input has disagreed with the
   // debounced level for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
   always_ff @(posedge clk_50MHz or posedge reset_button) begin
      if (reset_button) begin
         sync_1   <= '0;
         sync_2   <= '0;
         deb      <= '0;
         deb_prev <= '0;
         for (int i = 0; i < 3; i++) begin
            deb_cnt[i] <= '0;
         end
      end else begin
         sync_1   <= raw_in;
         sync_2   <= sync_1;
         deb_prev <= deb[1:0];
         for (int i = 0; i < 3; i++) begin
            if (sync_2[i] == deb[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               deb[i]     <= sync_2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign press_on   = deb[0] & ~deb_prev[0];
   assign press_off  = deb[1] & ~deb_prev[1];
   assign both_held  = deb[0] & deb[1];
   assign open_level = deb[2];

   // State, hold counter and the one-hot flags all update together so the flags never lag.
   always_ff @(posedge clk_50MHz or posedge reset_button) begin
      if (reset_button) begin
         state       <= ST_OFF;
         hold_cnt    <= '0;
         result_on   <= 1'b0;
         result_off  <= 1'b1;
         result_err  <= 1'b0;
         result_open <= 1'b0;
      end else begin
         state       <= next_state;
         hold_cnt    <= next_hold_cnt;
         result_on   <= (next_state == ST_ON);
         result_off  <= (next_state == ST_OFF);
         result_err  <= (next_state == ST_ERR);
         result_open <= (next_state == ST_OPEN);
      end
   end

   // Both buttons held wins over everything and restarts the ERR hold; ERR ignores the
   // sensor and presses until the hold has fully elapsed.
   always_comb begin
      next_state    = state;
      next_hold_cnt = '0;
      if (both_held) begin
         next_state    = ST_ERR;
         next_hold_cnt = '0;
      end else begin
         case (state)
            ST_ERR: begin
               if (hold_cnt == HOLD_LAST) begin
                  next_state = ST_OFF;
               end else begin
                  next_hold_cnt = hold_cnt + 1'b1;
               end
            end
            ST_OFF: begin
               if (open_level) begin
                  next_state = ST_OPEN;
               end else if (press_on) begin
                  next_state = ST_ON;
               end
            end
            ST_ON: begin
               if (open_level) begin
                  next_state = ST_OPEN;
               end else if (press_off) begin
                  next_state = ST_OFF;
               end
            end
            ST_OPEN: begin
               if (!open_level) begin
                  next_state = ST_OFF;
               end
            end
            default: begin
               next_state = ST_OFF;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_status_input_ctrl.sv
// Directed bench for status_input_ctrl with short debounce (4) and ERR hold (16) timings;
// expected flag patterns are written as {on, off, err, open}.
module tb_status_input_ctrl;

   localparam logic [3:0] EXP_OFF  = 4'b0100;
   localparam logic [3:0] EXP_ON   = 4'b1000;
   localparam logic [3:0] EXP_ERR  = 4'b0010;
   localparam logic [3:0] EXP_OPEN = 4'b0001;

   logic clk_50MHz;
   logic reset_button;
   logic btn_on_raw;
   logic btn_off_raw;
   logic sw_open_raw;
   logic result_on;
   logic result_off;
   logic result_err;
   logic result_open;

   int compared;
   int mismatched;

   status_input_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .ERR_HOLD_CYCLES(16),
      .CNT_W(8)
   ) dut (
      .clk_50MHz(clk_50MHz),
      .reset_button(reset_button),
      .btn_on_raw(btn_on_raw),
      .btn_off_raw(btn_off_raw),
      .sw_open_raw(sw_open_raw),
      .result_on(result_on),
      .result_off(result_off),
      .result_err(result_err),
      .result_open(result_open)
   );

   initial clk_50MHz = 1'b0;
   always #5 clk_50MHz = ~clk_50MHz;

   function automatic logic [3:0] flags();
      return {result_on, result_off, result_err, result_open};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
         $error("[TB] check %s did not hold", tag);
      end
   endtask

   // Advance n clock edges, sampling 1 time unit after each edge; flags must be one-hot every cycle.
   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_50MHz);
         #1;
         checkOutput("onehot", 32'($onehot(flags())), 32'd1);
      end
   endtask

   initial begin
      compared     = 0;
      mismatched   = 0;
      reset_button = 1'b1;
      btn_on_raw   = 1'b0;
      btn_off_raw  = 1'b0;
      sw_open_raw  = 1'b0;

      // Reset state
      applyStimulus(3);
      checkOutput("reset_flags", 32'(flags()), 32'(EXP_OFF));
      reset_button = 1'b0;
      applyStimulus(3);
      checkOutput("post_reset_flags", 32'(flags()), 32'(EXP_OFF));

      // Bounce rejection: toggle every 2 cycles for 20 cycles
      for (int k = 0; k < 10; k++) begin
         btn_on_raw = ~btn_on_raw;
         applyStimulus(2);
         checkOutput("bounce_off", 32'(result_off), 32'd1);
      end
      btn_on_raw = 1'b0;
      applyStimulus(8);
      checkOutput("bounce_settled", 32'(flags()), 32'(EXP_OFF));

      // Press latency: 2 sync + 4 debounce + 1 state cycles
      btn_on_raw = 1'b1;
      applyStimulus(6);
      checkOutput("press_not_yet", 32'(flags()), 32'(EXP_OFF));
      applyStimulus(1);
      checkOutput("press_on_exact", 32'(flags()), 32'(EXP_ON));
      btn_on_raw = 1'b0;
      applyStimulus(10);
      checkOutput("on_after_release", 32'(flags()), 32'(EXP_ON));

      btn_off_raw = 1'b1;
      applyStimulus(10);
      btn_off_raw = 1'b0;
      applyStimulus(10);
      checkOutput("off_pulse", 32'(flags()), 32'(EXP_OFF));

      // Off press while already OFF: no change
      btn_off_raw = 1'b1;
      applyStimulus(10);
      btn_off_raw = 1'b0;
      applyStimulus(10);
      checkOutput("off_in_off", 32'(flags()), 32'(EXP_OFF));

      // Open sensor from ON
      btn_on_raw = 1'b1;
      applyStimulus(8);
      btn_on_raw = 1'b0;
      applyStimulus(8);
      checkOutput("on_before_open", 32'(flags()), 32'(EXP_ON));
      sw_open_raw = 1'b1;
      applyStimulus(7);
      checkOutput("open_from_on", 32'(flags()), 32'(EXP_OPEN));
      btn_on_raw = 1'b1;
      applyStimulus(8);
      btn_on_raw = 1'b0;
      applyStimulus(8);
      checkOutput("open_ignores_on", 32'(flags()), 32'(EXP_OPEN));
      btn_off_raw = 1'b1;
      applyStimulus(8);
      btn_off_raw = 1'b0;
      applyStimulus(8);
      checkOutput("open_ignores_off", 32'(flags()), 32'(EXP_OPEN));
      sw_open_raw = 1'b0;
      applyStimulus(7);
      checkOutput("open_release_off", 32'(flags()), 32'(EXP_OFF));

      // Error: both held, hold restarts while held, 16-cycle hold after release
      btn_on_raw  = 1'b1;
      btn_off_raw = 1'b1;
      applyStimulus(7);
      checkOutput("both_err", 32'(flags()), 32'(EXP_ERR));
      applyStimulus(30);
      checkOutput("err_while_held", 32'(flags()), 32'(EXP_ERR));
      checkOutput("hold_cnt_held", 32'(dut.hold_cnt), 32'd0);
      btn_on_raw  = 1'b0;
      btn_off_raw = 1'b0;
      applyStimulus(21);
      checkOutput("err_hold_last", 32'(flags()), 32'(EXP_ERR));
      applyStimulus(1);
      checkOutput("err_exit_off", 32'(flags()), 32'(EXP_OFF));
      applyStimulus(10);
      checkOutput("off_after_err", 32'(flags()), 32'(EXP_OFF));

      // Held button after ERR exit gives no new press
      btn_on_raw  = 1'b1;
      btn_off_raw = 1'b1;
      applyStimulus(10);
      btn_off_raw = 1'b0;
      applyStimulus(30);
      checkOutput("held_no_press", 32'(flags()), 32'(EXP_OFF));
      btn_on_raw = 1'b0;
      applyStimulus(10);

      // Reset in the middle of the ERR hold
      btn_on_raw  = 1'b1;
      btn_off_raw = 1'b1;
      applyStimulus(7);
      checkOutput("err_again", 32'(flags()), 32'(EXP_ERR));
      btn_on_raw  = 1'b0;
      btn_off_raw = 1'b0;
      applyStimulus(10);
      checkOutput("err_mid_hold", 32'(flags()), 32'(EXP_ERR));
      reset_button = 1'b1;
      #1;
      checkOutput("reset_mid_err", 32'(flags()), 32'(EXP_OFF));
      checkOutput("reset_hold_cnt", 32'(dut.hold_cnt), 32'd0);
      applyStimulus(2);
      reset_button = 1'b0;
      applyStimulus(30);
      checkOutput("no_err_after_reset", 32'(flags()), 32'(EXP_OFF));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
